// File: rtl/bridge_pio_in_edge_pkg.sv
// Shared constants for the edge-capturing input PIO: register offsets and capture modes.
// No logic, no latency.
// No flow control; constants only.
package bridge_pio_pkg;

    // Avalon word offsets of the register map
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Which transitions of the synchronised input set a capture bit
    typedef enum int {
        EDGE_RISE = 0,
        EDGE_FALL = 1,
        EDGE_ANY  = 2
    } edge_type_e;

endpackage

// File: rtl/bridge_pio_in_edge_if.sv
// Avalon-MM slave bus plus interrupt line of the input PIO.
// Wires only, no latency.
// No backpressure: Avalon slave with fixed read latency, no waitrequest.
interface bridge_pio_in_edge_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );
endinterface

// File: rtl/bridge_pio_in_edge_sync.sv
// Two-flop synchroniser bringing asynchronous board inputs into the clk domain.
// Latency: 2 clocks from input change to output.
// No backpressure; free-running every clock.
module bridge_pio_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;

    // Two back-to-back flops; both clear to 0 so the downstream edge logic starts from a known level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/bridge_pio_in_edge.sv
// Parametrised Avalon-MM input PIO with synchroniser, per-bit edge capture and maskable level irq.
// Latency: input->DATA 2 clocks, input->EDGE 3 clocks, read data 1 clock after address.
// No backpressure: every access completes in one cycle; a capture set beats a same-cycle clear.
module bridge_pio_in_edge
    import bridge_pio_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               EDGE_TYPE  = EDGE_RISE,
    parameter bit               IRQ_EN     = 1'b1,
    parameter logic [WIDTH-1:0] RESET_MASK = '0
) (
    input  logic                clk,
    input  logic                reset,
    bridge_pio_in_edge_if.slave bus,
    input  logic [WIDTH-1:0]    in_port
);

    if ((WIDTH < 1) || (WIDTH > 32)) begin : g_bad_width
        $error("bridge_pio_in_edge: WIDTH must be in 1..32");
    end
    if ((EDGE_TYPE < 0) || (EDGE_TYPE > 2)) begin : g_bad_edge_type
        $error("bridge_pio_in_edge: EDGE_TYPE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] w_s2;
    logic [WIDTH-1:0] r_s3;
    logic [1:0]       r_prime;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic             w_primed;
    logic [WIDTH-1:0] w_wdat;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] w_new;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_mask_eff;
    logic [31:0]      w_rdmux;
    logic             w_unused;

    bridge_pio_sync #(.WIDTH(WIDTH)) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (in_port),
        .o_q   (w_s2)
    );

    assign w_wr     = bus.chipselect & ~bus.write_n;
    assign w_wdat   = bus.writedata[WIDTH-1:0];
    // Writedata bits above WIDTH carry no meaning for this port
    assign w_unused = ^bus.writedata;

    // The prime counter holds off capture until s2/s3 both hold real post-reset samples,
    // so an input already high at reset is not mistaken for a rising edge.
    assign w_primed = (r_prime == 2'd3);
    assign w_rise   = w_s2 & ~r_s3;
    assign w_fall   = ~w_s2 & r_s3;

    // Pick the transitions that count as a capture for this build
    always_comb begin
        w_sel = '0;
        case (EDGE_TYPE)
            EDGE_RISE: w_sel = w_rise;
            EDGE_FALL: w_sel = w_fall;
            default:   w_sel = w_rise | w_fall;
        endcase
    end

    assign w_new      = w_primed ? w_sel : '0;
    assign w_clr      = (w_wr && (bus.address == ADDR_EDGE)) ? w_wdat : '0;
    assign w_mask_eff = IRQ_EN ? r_mask : '0;

    // Delayed copy of the synchronised input for edge detection, and the saturating prime counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3    <= '0;
            r_prime <= 2'd0;
        end else begin
            r_s3 <= w_s2;
            if (!w_primed) begin
                r_prime <= r_prime + 2'd1;
            end
        end
    end

    // Capture and mask registers; a new edge is OR-ed in after the clear so it is never lost
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
            r_mask <= RESET_MASK;
        end else begin
            r_edge <= (r_edge & ~w_clr) | w_new;
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= w_wdat;
            end
        end
    end

    // Read mux on address alone; upper bits stay zero for narrow ports
    always_comb begin
        w_rdmux = '0;
        case (bus.address)
            ADDR_DATA: w_rdmux[WIDTH-1:0] = w_s2;
            ADDR_MASK: w_rdmux[WIDTH-1:0] = w_mask_eff;
            ADDR_EDGE: w_rdmux[WIDTH-1:0] = r_edge;
            default:   w_rdmux = '0;
        endcase
    end

    // Registered read data, updated every clock regardless of chipselect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdmux;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = IRQ_EN && (|(r_edge & w_mask_eff));

endmodule

// File: tb/tb_bridge_pio_in_edge.sv
// Bench for the input PIO: an 8-bit rising-edge build and a 32-bit any-edge build.
// Directed scenarios plus a randomized run compared against a sample-history model.
// Inputs driven 1ns after the rising edge, outputs checked at the same point.
module tb_bridge_pio_in_edge;
    import bridge_pio_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bridge_pio_in_edge_if if8 ();
    bridge_pio_in_edge_if if32 ();
    logic [7:0]  in8;
    logic [31:0] in32;

    bridge_pio_in_edge #(.WIDTH(8), .EDGE_TYPE(0), .IRQ_EN(1'b1), .RESET_MASK(8'h5A)) dut8 (
        .clk(clk), .reset(reset), .bus(if8.slave), .in_port(in8));
    bridge_pio_in_edge #(.WIDTH(32), .EDGE_TYPE(2), .IRQ_EN(1'b1), .RESET_MASK(32'h0)) dut32 (
        .clk(clk), .reset(reset), .bus(if32.slave), .in_port(in32));

    int errors = 0;
    int checks = 0;

    // Reference model: history of input samples taken at each clock since reset
    logic [31:0] m_edge [2];
    logic [31:0] m_mask [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_hist [2][4];
    int          m_cnt  [2];

    task automatic model_step(input int u, input logic rst, input logic [1:0] a, input logic cs,
                              input logic wn, input logic [31:0] wd, input logic [31:0] inp,
                              input int w, input int et, input logic [31:0] rmask);
        logic [31:0] wm, data, cur, prev, nw, clr;
        wm = 32'((64'd1 << w) - 64'd1);
        if (rst) begin
            m_edge[u] = '0;
            m_mask[u] = rmask & wm;
            m_rd[u]   = '0;
            m_cnt[u]  = 0;
        end else begin
            // visible level = sample from two clocks ago (0 until that many samples exist)
            data = (m_cnt[u] >= 2) ? m_hist[u][1] : 32'h0;
            case (a)
                2'd0:    m_rd[u] = data;
                2'd2:    m_rd[u] = m_mask[u];
                2'd3:    m_rd[u] = m_edge[u];
                default: m_rd[u] = 32'h0;
            endcase
            nw = 32'h0;
            if (m_cnt[u] >= 3) begin
                cur  = m_hist[u][1];
                prev = m_hist[u][2];
                if (et == 0)      nw = cur & ~prev;
                else if (et == 1) nw = ~cur & prev;
                else              nw = cur ^ prev;
            end
            clr = (cs && !wn && a == 2'd3) ? wd : 32'h0;
            m_edge[u] = ((m_edge[u] & ~clr) | nw) & wm;
            if (cs && !wn && a == 2'd2) m_mask[u] = wd & wm;
            for (int j = 3; j > 0; j--) m_hist[u][j] = m_hist[u][j-1];
            m_hist[u][0] = inp & wm;
            if (m_cnt[u] < 4) m_cnt[u] = m_cnt[u] + 1;
        end
    endtask

    function automatic logic m_irq(input int u);
        return |(m_edge[u] & m_mask[u]);
    endfunction

    always @(posedge clk) begin
        model_step(0, reset, if8.address, if8.chipselect, if8.write_n, if8.writedata,
                   {24'h0, in8}, 8, 0, 32'h5A);
        model_step(1, reset, if32.address, if32.chipselect, if32.write_n, if32.writedata,
                   in32, 32, 2, 32'h0);
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr8(input logic [1:0] a, input logic [31:0] d);
        if8.address = a; if8.chipselect = 1'b1; if8.write_n = 1'b0; if8.writedata = d;
        cyc(1);
        if8.chipselect = 1'b0; if8.write_n = 1'b1;
    endtask

    task automatic wr32(input logic [1:0] a, input logic [31:0] d);
        if32.address = a; if32.chipselect = 1'b1; if32.write_n = 1'b0; if32.writedata = d;
        cyc(1);
        if32.chipselect = 1'b0; if32.write_n = 1'b1;
    endtask

    task automatic test_reset();
        in8 = 8'hFF;
        in32 = $urandom;
        if8.address = ADDR_DATA; if8.chipselect = 1'b0; if8.write_n = 1'b1; if8.writedata = '0;
        if32.address = ADDR_DATA; if32.chipselect = 1'b0; if32.write_n = 1'b1; if32.writedata = '0;
        cyc(3);
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL rst_rd8: got %h want 0", if8.readdata); end
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL rst_irq8: got %b want 0", if8.irq); end
        checks++; if (if32.readdata !== 32'h0) begin errors++; $display("FAIL rst_rd32: got %h want 0", if32.readdata); end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL prime_irq cyc%0d: got %b want 0", i, if8.irq); end
        end
        checks++; if (if8.readdata !== 32'hFF) begin errors++; $display("FAIL prime_data8: got %h want 000000ff", if8.readdata); end
        checks++; if (if32.readdata !== in32) begin errors++; $display("FAIL prime_data32: got %h want %h", if32.readdata, in32); end
        if8.address = ADDR_EDGE; if32.address = ADDR_EDGE;
        cyc(1);
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL prime_edge8: got %h want 0", if8.readdata); end
        checks++; if (if32.readdata !== 32'h0) begin errors++; $display("FAIL prime_edge32: got %h want 0", if32.readdata); end
        if8.address = ADDR_MASK;
        cyc(1);
        checks++; if (if8.readdata !== 32'h5A) begin errors++; $display("FAIL rst_mask8: got %h want 0000005a", if8.readdata); end
    endtask

    task automatic test_rising();
        if8.address = ADDR_EDGE;
        in8 = 8'hF7;
        cyc(6);
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL rise_fall_ignored: got %h want 0", if8.readdata); end
        in8 = 8'hFF;           // change just after edge t
        cyc(2);
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL rise_irq_t2: got %b want 0", if8.irq); end
        cyc(1);
        checks++; if (if8.irq !== 1'b1) begin errors++; $display("FAIL rise_irq_t3: got %b want 1", if8.irq); end
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL rise_rd_t3: got %h want 0", if8.readdata); end
        cyc(1);
        checks++; if (if8.readdata !== 32'h8) begin errors++; $display("FAIL rise_rd_t4: got %h want 00000008", if8.readdata); end
        in8 = 8'hF7;
        cyc(6);
        checks++; if (if8.readdata !== 32'h8) begin errors++; $display("FAIL rise_after_fall: got %h want 00000008", if8.readdata); end
    endtask

    task automatic test_mask();
        wr8(ADDR_MASK, 32'h0);
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL mask0_irq: got %b want 0", if8.irq); end
        wr8(ADDR_MASK, 32'h08);
        checks++; if (if8.irq !== 1'b1) begin errors++; $display("FAIL mask8_irq: got %b want 1", if8.irq); end
        if8.address = ADDR_MASK;
        cyc(1);
        checks++; if (if8.readdata !== 32'h08) begin errors++; $display("FAIL mask_rd: got %h want 00000008", if8.readdata); end
        wr8(ADDR_EDGE, 32'h08);
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL clr_irq: got %b want 0", if8.irq); end
        cyc(1);
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL clr_rd: got %h want 0", if8.readdata); end
    endtask

    task automatic test_collision();
        wr8(ADDR_MASK, 32'h01);
        in8 = 8'hF6;
        cyc(6);
        wr8(ADDR_EDGE, 32'hFF);
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL col_pre_irq: got %b want 0", if8.irq); end
        in8 = 8'hF7;
        cyc(4);
        checks++; if (if8.irq !== 1'b1) begin errors++; $display("FAIL col_first_irq: got %b want 1", if8.irq); end
        in8 = 8'hF6;
        cyc(6);
        in8 = 8'hF7;           // edge t; capture lands at t+3
        cyc(2);
        wr8(ADDR_EDGE, 32'h01); // clear sampled at t+3 too
        checks++; if (if8.irq !== 1'b1) begin errors++; $display("FAIL col_irq: got %b want 1", if8.irq); end
        cyc(1);
        checks++; if (if8.readdata !== 32'h1) begin errors++; $display("FAIL col_rd: got %h want 00000001", if8.readdata); end
        wr8(ADDR_EDGE, 32'h01);
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL col_clr_irq: got %b want 0", if8.irq); end
    endtask

    task automatic test_any32();
        if32.address = ADDR_EDGE;
        in32 = in32 & 32'h7FFF_FFFF;
        cyc(6);
        wr32(ADDR_EDGE, 32'hFFFF_FFFF);
        wr32(ADDR_MASK, 32'h8000_0000);
        checks++; if (if32.irq !== 1'b0) begin errors++; $display("FAIL any_pre_irq: got %b want 0", if32.irq); end
        in32 = in32 | 32'h8000_0000;
        cyc(4);
        checks++; if (if32.irq !== 1'b1) begin errors++; $display("FAIL any_up_irq: got %b want 1", if32.irq); end
        cyc(1);
        checks++; if (if32.readdata !== 32'h8000_0000) begin errors++; $display("FAIL any_up_rd: got %h want 80000000", if32.readdata); end
        wr32(ADDR_EDGE, 32'h8000_0000);
        checks++; if (if32.irq !== 1'b0) begin errors++; $display("FAIL any_clr_irq: got %b want 0", if32.irq); end
        in32 = in32 & 32'h7FFF_FFFF;
        cyc(4);
        checks++; if (if32.irq !== 1'b1) begin errors++; $display("FAIL any_dn_irq: got %b want 1", if32.irq); end
        cyc(1);
        checks++; if (if32.readdata !== 32'h8000_0000) begin errors++; $display("FAIL any_dn_rd: got %h want 80000000", if32.readdata); end
        if32.address = ADDR_RSVD;
        cyc(1);
        checks++; if (if32.readdata !== 32'h0) begin errors++; $display("FAIL rsvd_rd: got %h want 0", if32.readdata); end
        wr32(ADDR_DATA, ~in32);
        cyc(1);
        checks++; if (if32.readdata !== in32) begin errors++; $display("FAIL data_wr_ignored: got %h want %h", if32.readdata, in32); end
    endtask

    task automatic test_reset_mid();
        wr8(ADDR_MASK, 32'hFF);
        in8 = 8'h07;
        cyc(6);
        wr8(ADDR_EDGE, 32'hFF);
        in8 = 8'hF7;
        cyc(5);
        checks++; if (if8.irq !== 1'b1) begin errors++; $display("FAIL mid_pre_irq: got %b want 1", if8.irq); end
        checks++; if (if8.readdata !== 32'hF0) begin errors++; $display("FAIL mid_pre_edge: got %h want 000000f0", if8.readdata); end
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        checks++; if (if8.irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b want 0", if8.irq); end
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL mid_rd: got %h want 0", if8.readdata); end
        if8.address = ADDR_MASK;
        cyc(1);
        checks++; if (if8.readdata !== 32'h5A) begin errors++; $display("FAIL mid_mask: got %h want 0000005a", if8.readdata); end
        if8.address = ADDR_EDGE;
        cyc(1);
        checks++; if (if8.readdata !== 32'h0) begin errors++; $display("FAIL mid_edge: got %h want 0", if8.readdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            reset = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) in8 = in8 ^ 8'($urandom);
            if ($urandom_range(0, 2) == 0) in32 = in32 ^ ($urandom & $urandom);
            if8.address = 2'($urandom); if8.chipselect = $urandom_range(0, 1) == 1;
            if8.write_n = $urandom_range(0, 3) != 0; if8.writedata = $urandom;
            if32.address = 2'($urandom); if32.chipselect = $urandom_range(0, 1) == 1;
            if32.write_n = $urandom_range(0, 3) != 0; if32.writedata = $urandom;
            cyc(1);
            checks++; if (if8.readdata !== m_rd[0]) begin errors++; $display("FAIL rnd_rd8 cyc%0d: got %h want %h", i, if8.readdata, m_rd[0]); end
            checks++; if (if8.irq !== m_irq(0)) begin errors++; $display("FAIL rnd_irq8 cyc%0d: got %b want %b", i, if8.irq, m_irq(0)); end
            checks++; if (if32.readdata !== m_rd[1]) begin errors++; $display("FAIL rnd_rd32 cyc%0d: got %h want %h", i, if32.readdata, m_rd[1]); end
            checks++; if (if32.irq !== m_irq(1)) begin errors++; $display("FAIL rnd_irq32 cyc%0d: got %b want %b", i, if32.irq, m_irq(1)); end
        end
        reset = 1'b0;
        if8.chipselect = 1'b0; if32.chipselect = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_rising();
        test_mask();
        test_collision();
        test_any32();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
